// File: rtl/accum_alu_pkg.sv
// Shared encodings for the accumulator ALU: FSM states, opcodes and the
// saturation-direction helper.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_READY = 2'b01,
        ST_RUN   = 2'b10,
        ST_ERROR = 2'b11
    } state_e;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOT  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_MUL  = 3'b110,
        OP_LOAD = 3'b111
    } op_e;

    // Overflowing ADD/MUL clamp to all-ones; SUB underflow clamps to zero.
    function automatic logic sat_to_ones(op_e op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/accum_alu_if.sv
// Operand/result handshake bundle between the operand source and accum_alu.
interface accum_alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             use_acc;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             overflow;
    logic [1:0]       state;

    modport master (
        output in_valid, op, use_acc, a_in, b_in,
        input  in_ready, result, out_valid, overflow, state
    );

    modport slave (
        input  in_valid, op, use_acc, a_in, b_in,
        output in_ready, result, out_valid, overflow, state
    );
endinterface

// File: rtl/accum_alu_mult.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles,
// full 2*WIDTH-bit product presented combinationally alongside done_o.
module seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] step_sum;
    logic               last_step;

    assign step_sum  = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            prod_d   = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            prod_d   = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (last_step) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    // The final partial sum is the product, so the last RUN edge can commit it.
    assign busy_o    = busy_q;
    assign done_o    = busy_q && last_step;
    assign product_o = step_sum;

endmodule

// File: rtl/accum_alu.sv
// Handshaked WIDTH-bit accumulator ALU with OFF/READY/RUN/ERROR control,
// single-cycle logic/add/sub and an iterative multiplier.
module accum_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      on,
    accum_alu_if.slave bus
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic               overflow_q, overflow_d;

    op_e                op_in;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH:0]     add_w;
    logic [WIDTH-1:0]   alu_raw, alu_res;
    logic               alu_ovf;

    logic               mult_start, mult_busy, mult_done;
    logic [2*WIDTH-1:0] mult_prod;
    logic               mul_ovf;
    logic [WIDTH-1:0]   mul_res;

    assign op_in = op_e'(bus.op);
    assign a_sel = bus.use_acc ? acc_q : bus.a_in;
    assign add_w = {1'b0, a_sel} + {1'b0, bus.b_in};

    always_comb begin
        alu_raw = '0;
        alu_ovf = 1'b0;
        case (op_in)
            OP_AND:  alu_raw = a_sel & bus.b_in;
            OP_OR:   alu_raw = a_sel | bus.b_in;
            OP_XOR:  alu_raw = a_sel ^ bus.b_in;
            OP_NOT:  alu_raw = ~a_sel;
            OP_ADD: begin
                alu_raw = add_w[WIDTH-1:0];
                alu_ovf = add_w[WIDTH];
            end
            OP_SUB: begin
                alu_raw = a_sel - bus.b_in;
                alu_ovf = (a_sel < bus.b_in);
            end
            OP_LOAD: alu_raw = bus.b_in;
            default: alu_raw = '0;
        endcase
        alu_res = alu_raw;
        if ((SATURATE != 0) && alu_ovf) begin
            alu_res = sat_to_ones(op_in) ? '1 : '0;
        end
    end

    seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mult_start),
        .a_i       (a_sel),
        .b_i       (bus.b_in),
        .busy_o    (mult_busy),
        .done_o    (mult_done),
        .product_o (mult_prod)
    );

    assign mul_ovf = |mult_prod[2*WIDTH-1:WIDTH];
    assign mul_res = ((SATURATE != 0) && mul_ovf) ? '1 : mult_prod[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        overflow_d  = 1'b0;
        mult_start  = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (on) state_d = ST_READY;
            end
            ST_READY: begin
                if (!on) begin
                    state_d = ST_OFF;
                end else if (bus.in_valid) begin
                    if (op_in == OP_MUL) begin
                        mult_start = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        acc_d       = alu_res;
                        out_valid_d = 1'b1;
                        overflow_d  = alu_ovf;
                        state_d     = alu_ovf ? ST_ERROR : ST_READY;
                    end
                end
            end
            ST_RUN: begin
                if (mult_done) begin
                    acc_d       = mul_res;
                    out_valid_d = 1'b1;
                    overflow_d  = mul_ovf;
                    state_d     = mul_ovf ? ST_ERROR : ST_READY;
                end else if (!mult_busy) begin
                    state_d = ST_READY;
                end
            end
            ST_ERROR: state_d = ST_READY;
            default:  state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OFF;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    // Ready is gated by on so a power-down never looks like an accept.
    assign bus.in_ready  = (state_q == ST_READY) && on;
    assign bus.result    = acc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overflow  = overflow_q;
    assign bus.state     = state_q;

endmodule

// File: doc/accum_alu.md
# accum_alu

Parametrised, handshaked accumulator ALU. Generalises the 8-bit ALU datapath to WIDTH bits, adds a valid/ready operand interface, an iterative multi-cycle multiplier and an optional saturating mode, and keeps the OFF/READY/RUN/ERROR control FSM. Sits between the operand source (switch/bus front end) and the display/result consumer; the accumulator feeds back as operand A.

## Interface
- WIDTH, 8: operand, accumulator and result width (≥2).
- SATURATE, 0: 1 = clamp overflowing results; 0 = wrap (truncate).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- on  in  1  power enable; sampled in OFF and READY only.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  high only in READY.
- op  in  3  000 AND, 001 OR, 010 XOR, 011 NOT(~A), 100 ADD, 101 SUB, 110 MUL, 111 LOAD (acc←B).
- use_acc  in  1  A = acc when 1, else a_in.
- a_in, b_in  in  WIDTH  operands, unsigned.
- result  out  WIDTH  registered; equals accumulator.
- out_valid  out  1  one-cycle pulse per completed op.
- overflow  out  1  qualified by out_valid.
- state  out  2  current FSM state.

## Operation
- Package encodings: OFF=00, READY=01, RUN=10, ERROR=11.
- OFF: in_ready=0; on=1 → READY.
- READY: on=0 → OFF (takes priority over accept). Accept = in_valid & in_ready. The accept edge captures A, B and op.
- Non-MUL accept: acc/result written on the accept edge. out_valid=1 in the following cycle. Next state is ERROR if overflow, else READY.
- MUL accept: → RUN. Shift-add, one multiplier bit per cycle, WIDTH cycles, 2·WIDTH-bit product. On the last RUN edge, acc/result are written and the next state is ERROR or READY.
- `on` is ignored in RUN and ERROR. The op always completes.
- ERROR: lasts exactly one cycle, carrying out_valid=1 and overflow=1, with in_ready=0. Then → READY.
- Overflow rules:
  - ADD: carry out of bit WIDTH-1.
  - SUB: borrow (A<B).
  - MUL: upper WIDTH product bits ≠ 0.
  - Logic ops and LOAD: never overflow.
- Result on overflow:
  - SATURATE=0: low WIDTH bits.
  - SATURATE=1: ADD/MUL → all-ones; SUB → 0.
- The accumulator is always updated with the delivered result.
- Reset state: state=OFF, result/acc=0, out_valid=0, overflow=0, in_ready=0, multiplier counter=0. Reset mid-RUN aborts the op with no out_valid.

## Timing
- Non-MUL latency: 1 cycle from accept edge to out_valid. Back-to-back accepts every cycle are allowed when there is no overflow.
- MUL latency: WIDTH cycles. in_ready=0 for WIDTH cycles.
- Overflow adds 1 back-pressure cycle (ERROR).
- use_acc=1 on the cycle right after a result reads the new acc value. No hazard.
- in_valid while in_ready=0 is ignored. The source must hold it.

## Structure
- Package alu_pkg: state encodings, op encodings, overflow/saturation helper function.
- Sub-module seq_mult (WIDTH param): start, busy, done, 2·WIDTH product, counter.
- Top: FSM, operand capture, combinational logic/add/sub unit, result/acc register.

## Test plan
- Reset/power, WIDTH=8:
  - rst=1 → state=00, result=0x00, in_ready=0.
  - Release rst with on=1 → state=01 one cycle later.
  - on=0 in READY → 00.
- Wrapping ADD, SATURATE=0:
  - ADD 0x70+0x20 (use_acc=0) → result=0x90, overflow=0, 1 cycle latency.
  - Then ADD use_acc, B=0x80 → 0x10, overflow=1, state=11 one cycle, then 01.
- Saturating ADD/SUB, SATURATE=1:
  - ADD 0x90+0x80 → 0xFF, overflow=1.
  - SUB 0x05−0x07 → 0x00, overflow=1.
  - With SATURATE=0, the same SUB → 0xFE.
- MUL:
  - 0x0F×0x11 → 0xFF, no overflow. in_ready=0 for exactly 8 cycles, state=10 throughout.
  - 0x10×0x10 → 0x00 with overflow=1 (SATURATE=1: 0xFF).
- Back-to-back chain, in_valid held high:
  - Sequence: LOAD 0x3C; AND(acc,0x0F); XOR(acc,0xFF); NOT(acc).
  - Results 0x3C, 0x0C, 0xF3, 0x0C on consecutive cycles. out_valid high 4 cycles.
- Reset mid-MUL: rst at RUN cycle 3 → next cycle state=00, result=0x00. No out_valid pulse afterwards.
